// File: rtl/regfile_wr_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wr_arb_if
//  Description : Write-port bus between write-back / auxiliary producers and
//                the register file write arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
interface regfile_wr_arb_if #(
    parameter int N_AUX = 2
) ();
    logic                   wb_we;
    logic [4:0]             wb_waddr;
    logic [31:0]            wb_wdata;
    logic [N_AUX-1:0]       aux_valid;
    logic [5*N_AUX-1:0]     aux_waddr;
    logic [32*N_AUX-1:0]    aux_wdata;
    logic [N_AUX-1:0]       aux_ready;
    logic                   rf_we;
    logic [4:0]             rf_waddr;
    logic [31:0]            rf_wdata;

    modport master (
        output wb_we, wb_waddr, wb_wdata, aux_valid, aux_waddr, aux_wdata,
        input  aux_ready, rf_we, rf_waddr, rf_wdata
    );

    modport slave (
        input  wb_we, wb_waddr, wb_wdata, aux_valid, aux_waddr, aux_wdata,
        output aux_ready, rf_we, rf_waddr, rf_wdata
    );
endinterface
`default_nettype wire

// File: rtl/regfile_wr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wr_arb
//  Description : Register-file write-port arbiter: pipeline write-back first,
//                auxiliary producers round-robin, plus a pending scoreboard.
//                Starvation guard enabled by REGWR_ARB_STARVE_GUARD_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_wr_arb #(
    parameter int N_AUX        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_wr_arb_if.slave      bus,
    input  logic                 claim_we,
    input  logic [4:0]           claim_addr,
    input  logic [4:0]           raddr1,
    input  logic [4:0]           raddr2,
    output logic                 busy1,
    output logic                 busy2,
    output logic                 stall_req
);

    localparam int PTR_W = $clog2(N_AUX);

    logic [PTR_W-1:0]  r_rr_ptr;
    logic [31:0]       r_pending;
    logic [31:0]       w_pending_nxt;
    logic              w_wb_live;
    logic              w_found;
    logic              w_hs;
    logic [PTR_W-1:0]  w_win;
    logic [4:0]        w_win_addr;
    logic [31:0]       w_win_data;

    assign w_wb_live = bus.wb_we && (bus.wb_waddr != 5'd0);

    // Rotating priority search starting at the round-robin pointer.
    always_comb begin : p_search
        int idx;
        idx     = 0;
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < N_AUX; k++) begin
            idx = (int'(r_rr_ptr) + k) % N_AUX;
            if (!w_found && bus.aux_valid[idx]) begin
                w_found = 1'b1;
                w_win   = PTR_W'(idx);
            end
        end
    end

    assign w_win_addr = bus.aux_waddr[5*int'(w_win) +: 5];
    assign w_win_data = bus.aux_wdata[32*int'(w_win) +: 32];
    assign w_hs       = rst_n && !w_wb_live && w_found;

    always_comb begin : p_port
        bus.rf_we     = 1'b0;
        bus.rf_waddr  = 5'd0;
        bus.rf_wdata  = 32'd0;
        bus.aux_ready = '0;
        if (rst_n) begin
            if (w_wb_live) begin
                bus.rf_we    = 1'b1;
                bus.rf_waddr = bus.wb_waddr;
                bus.rf_wdata = bus.wb_wdata;
            end else if (w_found) begin
                bus.aux_ready[w_win] = 1'b1;
                bus.rf_we            = (w_win_addr != 5'd0);
                bus.rf_waddr         = w_win_addr;
                bus.rf_wdata         = w_win_data;
            end
        end
    end

    // Claim is applied after the clear so a same-cycle claim survives.
    always_comb begin : p_pending_nxt
        w_pending_nxt = r_pending;
        if (w_hs && (w_win_addr != 5'd0)) begin
            w_pending_nxt[w_win_addr] = 1'b0;
        end
        if (claim_we && (claim_addr != 5'd0)) begin
            w_pending_nxt[claim_addr] = 1'b1;
        end
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 32'd0;
            r_rr_ptr  <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            if (w_hs) begin
                r_rr_ptr <= (w_win == PTR_W'(N_AUX - 1)) ? '0 : w_win + PTR_W'(1);
            end
        end
    end

    // A register written by an auxiliary producer this cycle is forwarded by
    // the register file, so it is not reported busy.
    assign busy1 = rst_n && r_pending[raddr1] && !(w_hs && (w_win_addr == raddr1));
    assign busy2 = rst_n && r_pending[raddr2] && !(w_hs && (w_win_addr == raddr2));

`ifdef REGWR_ARB_STARVE_GUARD_EN
    localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);

    logic [3:0] r_wait_cnt;
    logic       r_stall_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt  <= 4'd0;
            r_stall_req <= 1'b0;
        end else begin
            if (w_hs || (bus.aux_valid == '0)) begin
                r_wait_cnt <= 4'd0;
            end else if (r_wait_cnt != 4'hF) begin
                r_wait_cnt <= r_wait_cnt + 4'd1;
            end
            r_stall_req <= (r_wait_cnt >= c_starve_limit);
        end
    end

    assign stall_req = r_stall_req;
`else
    assign stall_req = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/regfile_wr_arb.md
Name: regfile_wr_arb

Overview:
- Arbitrates the general-purpose register file's single write port between the main pipeline write-back stage and N_AUX auxiliary multi-cycle producers, such as the divider and the load-miss return.
- The pipeline write-back always has priority. Auxiliary producers share the remaining slots round-robin using a valid/ready handshake.
- A 32-entry pending scoreboard tracks registers claimed by in-flight auxiliary operations, so decode can detect RAW hazards.
- The block sits between the write-back/auxiliary units and the register file write port.

Parameters:
- N_AUX, 2, number of auxiliary requesters (legal range 2..4).
- STARVE_LIMIT, 4, number of consecutive cycles an auxiliary request may wait before stall_req is raised (legal range 1..15).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- wb_we  in  1  pipeline write-back write enable.
- wb_waddr  in  5  pipeline write-back destination register.
- wb_wdata  in  32  pipeline write-back data.
- aux_valid  in  N_AUX  per-requester write request.
- aux_waddr  in  5*N_AUX  per-requester destination; requester i occupies bits [5i+4:5i].
- aux_wdata  in  32*N_AUX  per-requester data; requester i occupies bits [32i+31:32i].
- aux_ready  out  N_AUX  per-requester grant; a handshake occurs when valid and ready are both 1.
- claim_we  in  1  issue stage marks a destination as pending for an auxiliary operation.
- claim_addr  in  5  register being claimed.
- rf_we  out  1  register file write enable.
- rf_waddr  out  5  register file write address.
- rf_wdata  out  32  register file write data.
- raddr1  in  5  decode read port 1 address, used for the busy query.
- raddr2  in  5  decode read port 2 address, used for the busy query.
- busy1  out  1  register at raddr1 is pending.
- busy2  out  1  register at raddr2 is pending.
- stall_req  out  1  request that the pipeline suppress write-back so a starved auxiliary requester can win.

Behaviour:
- Sequential state:
  - pending[31:0].
  - rr_ptr, width clog2(N_AUX).
  - wait_cnt, 4 bits.
  - stall_req, registered.
- Reset: all of this state is cleared to 0 asynchronously. While rst_n=0, every output is forced to 0.
- Grant decision is combinational and resolved in the same cycle; the write reaches the register file with zero added latency.
- A WB slot is "live" when wb_we=1 and wb_waddr!=0. A write-back to r0 counts as no write-back, and the port is free for auxiliary requesters.
- Live WB slot:
  - rf_we=1, rf_waddr=wb_waddr, rf_wdata=wb_wdata.
  - aux_ready is all 0.
- No live WB slot:
  - Search aux_valid starting at index rr_ptr and wrapping upward. The first valid index i wins and aux_ready[i]=1; every other ready bit is 0.
  - rf_waddr and rf_wdata come from requester i. rf_we=1 only if aux_waddr[i]!=0.
  - A request to r0 is still handshaken and consumed; no write occurs.
- No request at all: rf_we=0. rf_waddr and rf_wdata are driven to 0.
- rr_ptr is updated only on an auxiliary handshake, to (i+1) mod N_AUX.
- Protocol rule: a requester holds valid, waddr and wdata stable until its handshake. The arbiter tolerates early deassertion; that request simply loses its slot.
- Scoreboard:
  - claim_we=1 with claim_addr!=0 sets pending[claim_addr] on the next edge.
  - An auxiliary handshake with waddr!=0 clears pending[waddr].
  - Set and clear of the same address in the same cycle: the set wins.
  - A pipeline WB write never changes pending.
  - pending[0] is always 0.
- Busy query:
  - busy1 = pending[raddr1] AND NOT (an auxiliary handshake writing raddr1 this cycle). busy2 is defined the same way.
  - A same-cycle write is visible through the register file's write-through read path, so that register is not reported busy.
- Starvation counter:
  - wait_cnt increments, saturating at 15, in each cycle where aux_valid!=0 and no auxiliary handshake occurs.
  - wait_cnt clears on any auxiliary handshake, or when aux_valid=0.
- stall_req is registered: it equals 1 on the cycle after wait_cnt reaches >= STARVE_LIMIT. It clears the cycle after wait_cnt clears.

Optional Feature:
- Macro: REGWR_ARB_STARVE_GUARD_EN.
- Defined: wait_cnt and stall_req are implemented as described above.
- Undefined: wait_cnt is not instantiated and stall_req is tied to 0. The pipeline WB can then starve auxiliary requesters indefinitely; the system must guarantee WB bubbles.

Test Plan:
- Reset check: hold rst_n=0 with wb_we=1, wb_waddr=3 and aux_valid=2'b11 -> rf_we=0, aux_ready=0, busy1=busy2=0, stall_req=0. Release reset -> WB write to r3 appears the same cycle.
- WB priority: wb_we=1 to r5 (data 0xDEADBEEF) and aux_valid=2'b01 to r6 -> rf writes r5 with 0xDEADBEEF, aux_ready=0. Next cycle with wb_we=0 -> aux0 is granted and r6 is written.
- Round-robin: aux_valid=2'b11 held for 4 cycles with no WB, each grant followed by a new request -> grants alternate aux0, aux1, aux0, aux1.
- R0 handling: wb_we=1 with wb_waddr=0 and aux1 valid -> aux1 is granted. Separately, aux0 to r0 -> aux_ready[0]=1, rf_we=0, and pending is unchanged.
- Scoreboard: claim r7, then raddr1=7 -> busy1=1. In the cycle of aux handshake to r7 -> busy1=0. Same-cycle claim and completion for r7 -> pending[7] remains 1 next cycle.
- Starvation (macro defined, STARVE_LIMIT=4): wb_we=1 every cycle and aux0 valid -> stall_req=1 on cycle 5. Drop wb_we -> aux0 is granted, and stall_req=0 two cycles later.
